matmul_accum_tree: RTL and testbench

Pipelined, handshaked reduction engine for the temporal-LUT matrix-multiply datapath. Each input beat carries KT LUT partial products for every one of the M×N result elements. The block reduces each group of KT products through a registered binary adder tree, accumulates successive beats (K-tiles) until a beat marked last, then presents the complete M×N result with a valid/ready handshake. It sits between the TLUT product stage and the result writeback.

---
 rtl/matmul_accum_tree_if.sv | 38 +++
 rtl/matmul_accum_tree.sv | 178 +++++++++++++++++
 tb/tb_matmul_accum_tree.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_accum_tree_if.sv
// matmul_accum_tree_if: handshake bundle for the matmul accumulation tree.
//   master : producer/consumer side (drives beats, accepts results)
//   slave  : reduction engine side
// Signals:
//   in_valid/in_ready/in_last  input beat handshake, in_last marks the final K-tile
//   prod                       M*N*KT signed products, element e, product p at e*KT+p
//   out_valid/out_ready        result handshake
//   out_data                   M*N accumulated results, element e at index e
//   out_beats                  beats accumulated into out_data (saturating)
//   out_sat                    sticky accumulator saturation flag
interface matmul_accum_tree_if #(
    parameter int unsigned M          = 4,
    parameter int unsigned N          = 4,
    parameter int unsigned KT         = 4,
    parameter int unsigned PROD_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic                             in_last;
    logic [M*N*KT*PROD_WIDTH-1:0]     prod;
    logic                             out_valid;
    logic                             out_ready;
    logic [M*N*ACC_WIDTH-1:0]         out_data;
    logic [CNT_WIDTH-1:0]             out_beats;
    logic                             out_sat;

    modport master (
        output in_valid, in_last, prod, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_sat
    );

    modport slave (
        input  in_valid, in_last, prod, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_sat
    );
endinterface

// File: rtl/matmul_accum_tree.sv
// matmul_accum_tree: pipelined reduction of KT LUT partial products per result element
// through a registered binary adder tree, followed by K-tile accumulation and a
// valid/ready result hold stage.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous abort, drops in-flight data and returns to idle
//   bus    matmul_accum_tree_if.slave (input beats, result handshake)
// Build option: define MATMUL_SAT_EN to saturate accumulator adds and drive out_sat;
// otherwise accumulation wraps and out_sat is tied low.
module matmul_accum_tree #(
    parameter int unsigned M          = 4,
    parameter int unsigned N          = 4,
    parameter int unsigned KT         = 4,
    parameter int unsigned PROD_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    matmul_accum_tree_if.slave bus
);
    localparam int unsigned E     = M * N;
    localparam int unsigned D     = $clog2(KT);
    localparam int unsigned NODES = 2 * KT - 1;
    localparam int unsigned EXT   = ACC_WIDTH - PROD_WIDTH;

    typedef enum logic [1:0] {StIdle, StAccum, StFlush, StHold} state_e;

    state_e state_q, state_d;

    logic                        in_rdy;
    logic                        accept;
    logic                        drain_done;
    logic                        handshake;
    logic [D:1]                  vld_q;
    logic [D:1]                  lst_q;
    // Heap layout per element: entries 0..KT-2 are registered internal nodes (0 is the
    // root), entries KT-1..2KT-2 are the sign-extended input products (leaves).
    logic signed [ACC_WIDTH-1:0] node_q   [E][KT-1];
    logic signed [ACC_WIDTH-1:0] node_all [E][NODES];
    logic signed [ACC_WIDTH-1:0] acc_q    [E];
    logic signed [ACC_WIDTH-1:0] acc_nxt  [E];
    logic [CNT_WIDTH-1:0]        cnt_q;

    assign in_rdy     = (state_q == StIdle) || (state_q == StAccum);
    assign accept     = bus.in_valid && in_rdy;
    assign drain_done = vld_q[D] && lst_q[D];
    assign handshake  = (state_q == StHold) && bus.out_ready;

    // Adder tree: every node level is one pipeline stage, so all leaves reach the root
    // after exactly D edges.
    always_comb begin
        for (int e = 0; e < E; e++) begin
            for (int i = 0; i < KT - 1; i++) begin
                node_all[e][i] = node_q[e][i];
            end
            for (int p = 0; p < KT; p++) begin
                node_all[e][KT-1+p] = {
                    {EXT{bus.prod[(e*KT+p)*PROD_WIDTH+PROD_WIDTH-1]}},
                    bus.prod[(e*KT+p)*PROD_WIDTH +: PROD_WIDTH]
                };
            end
        end
    end

    // Data registers carry no reset; only the tags decide what gets accumulated.
    always_ff @(posedge clk) begin
        for (int e = 0; e < E; e++) begin
            for (int i = 0; i < KT - 1; i++) begin
                node_q[e][i] <= node_all[e][2*i+1] + node_all[e][2*i+2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (clr) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[1] <= accept;
            lst_q[1] <= accept && bus.in_last;
            for (int s = 2; s <= D; s++) begin
                vld_q[s] <= vld_q[s-1];
                lst_q[s] <= lst_q[s-1];
            end
        end
    end

`ifdef MATMUL_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] acc_sum [E];
    logic [E-1:0]              ovf;
    logic                      sat_q;

    // One guard bit: overflow iff the two top bits of the widened sum disagree.
    always_comb begin
        ovf = '0;
        for (int e = 0; e < E; e++) begin
            acc_sum[e] = {acc_q[e][ACC_WIDTH-1], acc_q[e]}
                       + {node_q[e][0][ACC_WIDTH-1], node_q[e][0]};
            ovf[e]     = acc_sum[e][ACC_WIDTH] ^ acc_sum[e][ACC_WIDTH-1];
            if (ovf[e]) begin
                acc_nxt[e] = acc_sum[e][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_nxt[e] = acc_sum[e][ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (clr || handshake) begin
            sat_q <= 1'b0;
        end else if (vld_q[D]) begin
            sat_q <= sat_q | (|ovf);
        end
    end

    assign bus.out_sat = sat_q;
`else
    always_comb begin
        for (int e = 0; e < E; e++) begin
            acc_nxt[e] = acc_q[e] + node_q[e][0];
        end
    end

    assign bus.out_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < E; e++) acc_q[e] <= '0;
            cnt_q <= '0;
        end else if (clr || handshake) begin
            for (int e = 0; e < E; e++) acc_q[e] <= '0;
            cnt_q <= '0;
        end else if (vld_q[D]) begin
            for (int e = 0; e < E; e++) acc_q[e] <= acc_nxt[e];
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = bus.in_last ? StFlush : StAccum;
            StAccum: if (accept && bus.in_last) state_d = StFlush;
            StFlush: if (drain_done) state_d = StHold;
            StHold:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clr) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_beats = cnt_q;

    always_comb begin
        bus.out_data = '0;
        for (int e = 0; e < E; e++) begin
            bus.out_data[e*ACC_WIDTH +: ACC_WIDTH] = acc_q[e];
        end
    end
endmodule

// File: tb/tb_matmul_accum_tree.sv
// tb_matmul_accum_tree: directed bench for matmul_accum_tree with M=N=2, KT=4,
// PROD_WIDTH=16, ACC_WIDTH=18. Inputs change and outputs are sampled on the falling edge.
module tb_matmul_accum_tree;
    localparam int unsigned M  = 2;
    localparam int unsigned N  = 2;
    localparam int unsigned KT = 4;
    localparam int unsigned PW = 16;
    localparam int unsigned AW = 18;
    localparam int unsigned CW = 8;
    localparam int unsigned E  = M * N;

    logic clk;
    logic rst_n;
    logic clr;

    int errors;
    int checks;

    matmul_accum_tree_if #(
        .M(M), .N(N), .KT(KT), .PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) bus ();

    matmul_accum_tree #(
        .M(M), .N(N), .KT(KT), .PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] elem(input int e);
        logic [AW-1:0] v;
        v = bus.out_data[e*AW +: AW];
        return $signed(v);
    endfunction

    // mode 1: every product of element e equals e+1; mode 0: every product equals v
    task automatic set_prod(input int mode, input int v);
        for (int e = 0; e < E; e++) begin
            for (int p = 0; p < KT; p++) begin
                bus.prod[(e*KT+p)*PW +: PW] = (mode == 1) ? PW'(e + 1) : PW'(v);
            end
        end
    endtask

    // Present one beat for one cycle; it must be accepted.
    task automatic beat(input int mode, input int v, input logic last);
        set_prod(mode, v);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        chk("beat_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Cycles from the last beat's acceptance cycle until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", bus.out_valid, 1);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hs_valid_low", bus.out_valid, 0);
        chk("hs_ready_high", bus.in_ready, 1);
        chk("hs_beats_clr", bus.out_beats, 0);
    endtask

    initial begin
        int   lat;
        logic seen;
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.prod      = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_beats", bus.out_beats, 0);
        chk("rst_sat", bus.out_sat, 0);
        for (int e = 0; e < E; e++) chk("rst_data", elem(e), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat, products e+1 -> 4,8,12,16, latency 3
        beat(1, 0, 1'b1);
        chk("t1_flush_not_ready", bus.in_ready, 0);
        wait_out(lat);
        chk("t1_latency", lat, 3);
        chk("t1_e0", elem(0), 4);
        chk("t1_e1", elem(1), 8);
        chk("t1_e2", elem(2), 12);
        chk("t1_e3", elem(3), 16);
        chk("t1_beats", bus.out_beats, 1);
        handshake();

        // Three back-to-back beats 1, -2, 3 -> 4*(2) = 8
        beat(0, 1, 1'b0);
        beat(0, -2, 1'b0);
        beat(0, 3, 1'b1);
        chk("t2_ready_low", bus.in_ready, 0);
        wait_out(lat);
        chk("t2_latency", lat, 3);
        for (int e = 0; e < E; e++) chk("t2_elem", elem(e), 8);
        chk("t2_beats", bus.out_beats, 3);
        chk("t2_hold_ready", bus.in_ready, 0);

        // Stall with out_ready low and in_valid high: nothing accepted, data stable
        set_prod(0, 100);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", bus.out_valid, 1);
            chk("t3_stall_ready", bus.in_ready, 0);
            chk("t3_stall_e0", elem(0), 8);
            chk("t3_stall_beats", bus.out_beats, 3);
        end
        bus.in_valid = 1'b0;
        handshake();
        beat(0, 5, 1'b1);
        wait_out(lat);
        chk("t3_new_e0", elem(0), 20);
        chk("t3_new_e3", elem(3), 20);
        chk("t3_new_beats", bus.out_beats, 1);
        handshake();

        // clr one cycle after the last beat is accepted: no result ever
        beat(0, 7, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        chk("t4_no_valid", seen, 0);
        chk("t4_ready", bus.in_ready, 1);
        chk("t4_beats", bus.out_beats, 0);
        beat(0, 2, 1'b1);
        wait_out(lat);
        for (int e = 0; e < E; e++) chk("t4_elem", elem(e), 8);
        chk("t4_beats_after", bus.out_beats, 1);
        handshake();

        // Two beats of 32767: 2*131068 overflows 18 bits
        beat(0, 32767, 1'b0);
        beat(0, 32767, 1'b1);
        wait_out(lat);
`ifdef MATMUL_SAT_EN
        chk("t5_e0", elem(0), 131071);
        chk("t5_e3", elem(3), 131071);
        chk("t5_sat", bus.out_sat, 1);
`else
        chk("t5_e0", elem(0), -8);
        chk("t5_e3", elem(3), -8);
        chk("t5_sat", bus.out_sat, 0);
`endif
        chk("t5_beats", bus.out_beats, 2);
        handshake();
        chk("t5_sat_cleared", bus.out_sat, 0);

        // Asynchronous reset in the middle of accumulation
        beat(0, 1, 1'b0);
        beat(0, 1, 1'b0);
        beat(0, 1, 1'b0);
        chk("t6_pre_beats", bus.out_beats, 1);
        chk("t6_pre_e0", elem(0), 4);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_beats", bus.out_beats, 0);
        chk("t6_rst_e0", elem(0), 0);
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_ready", bus.in_ready, 1);
        beat(0, 5, 1'b1);
        wait_out(lat);
        chk("t6_new_e1", elem(1), 20);
        chk("t6_new_beats", bus.out_beats, 1);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
